// File: rtl/systolic_feeder_pkg.sv
// Shared types and constants for the systolic array feeder.
// Imported by the feeder top and its matrix register file.
package systolic_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_e;

    localparam int N_DEFAULT = 3;
    localparam int W_DEFAULT = 16;

    localparam logic [15:0] FP16_ZERO = 16'h0000;

endpackage

// File: rtl/mat_regfile.sv
// N*N x W matrix storage: one write port, every element tapped in parallel.
// Elements are packed row-major, element e at taps[e*W +: W].
module mat_regfile
    import systolic_feeder_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int W = W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             we,
    input  logic [3:0]       addr,
    input  logic [W-1:0]     wdata,
    output logic [N*N*W-1:0] taps
);

    localparam int NN = N * N;

    logic [NN*W-1:0] mem_q;
    logic [NN*W-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        for (int e = 0; e < NN; e++) begin
            if (we && int'(addr) == e) begin
                mem_d[e*W +: W] = wdata;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign taps = mem_q;

endmodule

// File: rtl/systolic_feeder.sv
// Streams two N x N matrices into a systolic array as skewed row/column
// wavefronts, then drains the array with zeros and pulses done.
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int W = W_DEFAULT
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           wr_en,
    input  logic           wr_sel,
    input  logic [3:0]     wr_addr,
    input  logic [W-1:0]   wr_data,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           clr,
    output logic [N*W-1:0] a_out,
    output logic [N*W-1:0] b_out
);

    localparam int NN = N * N;
    localparam int TW = (2 * N - 1 > 1) ? $clog2(2 * N - 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(2 * N - 2);
    localparam logic [TW-1:0] D_LAST = TW'(N - 1);

    state_e         state_q, state_d;
    logic [TW-1:0]  t_q, t_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           clr_q, clr_d;
    logic [N*W-1:0] a_out_q, a_out_d;
    logic [N*W-1:0] b_out_q, b_out_d;

    logic           wr_ok;
    logic           a_we;
    logic           b_we;
    logic [NN*W-1:0] a_taps;
    logic [NN*W-1:0] b_taps;

    assign wr_ok = wr_en && (state_q == IDLE) && (int'(wr_addr) < NN);
    assign a_we  = wr_ok && !wr_sel;
    assign b_we  = wr_ok && wr_sel;

    mat_regfile #(.N(N), .W(W)) u_mat_a (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (a_we),
        .addr    (wr_addr),
        .wdata   (wr_data),
        .taps    (a_taps)
    );

    mat_regfile #(.N(N), .W(W)) u_mat_b (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (b_we),
        .addr    (wr_addr),
        .wdata   (wr_data),
        .taps    (b_taps)
    );

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    t_d     = '0;
                end
            end
            STREAM: begin
                if (t_q == T_LAST) begin
                    state_d = DRAIN;
                    t_d     = '0;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            DRAIN: begin
                if (t_q == D_LAST) begin
                    state_d = IDLE;
                    t_d     = '0;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                t_d     = '0;
            end
        endcase
    end

    // Feeds are computed for the step being entered so they land in the
    // same cycle as the counter; a write coincident with start is forwarded.
    always_comb begin
        int k;
        int idx;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        k   = 0;
        idx = 0;
        va  = '0;
        vb  = '0;
        busy_d = (state_d != IDLE);
        clr_d  = (state_q == IDLE) && (state_d == STREAM);
        done_d = (state_d == DRAIN) && (t_d == D_LAST);
        for (int i = 0; i < N; i++) begin
            a_out_d[i*W +: W] = W'(FP16_ZERO);
            b_out_d[i*W +: W] = W'(FP16_ZERO);
            if (state_d == STREAM) begin
                k = int'(t_d) - i;
                if (k >= 0 && k < N) begin
                    idx = i * N + k;
                    va  = a_taps[idx*W +: W];
                    if (a_we && int'(wr_addr) == idx) va = wr_data;
                    a_out_d[i*W +: W] = va;
                    idx = k * N + i;
                    vb  = b_taps[idx*W +: W];
                    if (b_we && int'(wr_addr) == idx) vb = wr_data;
                    b_out_d[i*W +: W] = vb;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            t_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clr_q   <= 1'b0;
            a_out_q <= '0;
            b_out_q <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            clr_q   <= clr_d;
            a_out_q <= a_out_d;
            b_out_q <= b_out_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign clr   = clr_q;
    assign a_out = a_out_q;
    assign b_out = b_out_q;

endmodule
